// File: rtl/morra_pkg.sv
// Shared encodings for the rock-paper-scissors match controller.
// Holds the move and result codes, the controller state enum and the precedence rule.
// No logic of its own; imported by the judge and the top.
package morra_pkg;

  // Move encoding on PRIMO / SECONDO
  typedef enum logic [1:0] {
    MOSSA_NONE = 2'b00,
    SASSO      = 2'b01,
    CARTA      = 2'b10,
    FORBICE    = 2'b11
  } mossa_t;

  // Round / match result encoding on MANCHE / PARTITA
  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_DRAW = 2'b11
  } res_t;

  // Controller state
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    END  = 2'b10
  } state_t;

  // True when move a beats move b (both assumed valid and different).
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == SASSO)   && (b == FORBICE)) ||
           ((a == FORBICE) && (b == CARTA))   ||
           ((a == CARTA)   && (b == SASSO));
  endfunction

endpackage

// File: rtl/morra_judge.sv
// Purpose: combinational evaluator of one round from the two moves and the last-winner record.
// Latency: zero (pure combinational). Backpressure: none, result is valid every cycle.
// Ports: primo_i/secondo_i moves, last_win_i/last_mossa_i record, no_repeat_i rule enable, res_o result.
module morra_judge
  import morra_pkg::*;
(
  input  logic [1:0] primo_i,
  input  logic [1:0] secondo_i,
  input  logic [1:0] last_win_i,
  input  logic [1:0] last_mossa_i,
  input  logic       no_repeat_i,
  output logic [1:0] res_o
);

  logic any_none;
  logic p1_repeats;
  logic p2_repeats;

  assign any_none   = (primo_i == MOSSA_NONE) || (secondo_i == MOSSA_NONE);
  // The previous winner may not replay the move they won with.
  assign p1_repeats = no_repeat_i && (last_win_i == RES_P1) && (primo_i == last_mossa_i);
  assign p2_repeats = no_repeat_i && (last_win_i == RES_P2) && (secondo_i == last_mossa_i);

  always_comb begin
    res_o = RES_NONE;
    if (any_none || p1_repeats || p2_repeats) begin
      res_o = RES_NONE;
    end else if (primo_i == secondo_i) begin
      res_o = RES_DRAW;
    end else if (beats(primo_i, secondo_i)) begin
      res_o = RES_P1;
    end else begin
      res_o = RES_P2;
    end
  end

endmodule

// File: rtl/morra_cinese_param.sv
// Purpose: two-player rock-paper-scissors match controller with configurable length, lead and no-repeat rule.
// Latency: one cycle, every output is registered. Backpressure: none, one move pair is accepted per cycle.
// Ports: clk, RST_N (sync active-low), INIZIO start, PRIMO/SECONDO moves; MANCHE round, PARTITA match, CONTEGGIO rounds.
module morra_cinese_param
  import morra_pkg::*;
#(
  parameter int  MIN_MANCHE = 4,
  parameter int  LEAD       = 2,
  parameter int  NO_REPEAT  = 1,
  localparam int CNT_W      = $clog2(MIN_MANCHE + 16)
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             INIZIO,
  input  logic [1:0]       PRIMO,
  input  logic [1:0]       SECONDO,
  output logic [1:0]       MANCHE,
  output logic [1:0]       PARTITA,
  output logic [CNT_W-1:0] CONTEGGIO
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_MANCHE);
  localparam logic [CNT_W:0]   LEAD_X  = (CNT_W + 1)'(LEAD);

  state_t           state_q;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] score1_q;
  logic [CNT_W-1:0] score2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       last_win_q;
  logic [1:0]       last_mossa_q;
  logic [1:0]       manche_q;
  logic [1:0]       partita_q;

  logic [1:0]       round_res;
  logic             round_valid;
  logic [CNT_W-1:0] max_d;
  logic [CNT_W-1:0] score1_d;
  logic [CNT_W-1:0] score2_d;
  logic [CNT_W-1:0] cnt_d;
  logic             p1_lead;
  logic             p2_lead;
  logic             early_end;
  logic             max_end;
  logic [1:0]       leader_res;
  logic [1:0]       cmp_res;

  morra_judge u_judge (
    .primo_i      (PRIMO),
    .secondo_i    (SECONDO),
    .last_win_i   (last_win_q),
    .last_mossa_i (last_mossa_q),
    .no_repeat_i  (NO_REPEAT != 0),
    .res_o        (round_res)
  );

  assign round_valid = (round_res != RES_NONE);

  // On a start cycle the moves form a 4-bit extension of the minimum length.
  assign max_d = MIN_CNT + CNT_W'({PRIMO, SECONDO});

  // Post-update values: the end check uses the counts including this round.
  always_comb begin
    score1_d = score1_q;
    score2_d = score2_q;
    cnt_d    = cnt_q;
    if (round_valid) begin
      cnt_d = cnt_q + ONE;
    end
    if (round_res == RES_P1) begin
      score1_d = score1_q + ONE;
    end
    if (round_res == RES_P2) begin
      score2_d = score2_q + ONE;
    end
  end

  // One extra bit so adding LEAD cannot wrap.
  assign p1_lead    = {1'b0, score1_d} >= ({1'b0, score2_d} + LEAD_X);
  assign p2_lead    = {1'b0, score2_d} >= ({1'b0, score1_d} + LEAD_X);
  assign early_end  = (cnt_d >= MIN_CNT) && (p1_lead || p2_lead);
  assign leader_res = p1_lead ? RES_P1 : RES_P2;
  assign max_end    = (cnt_d == max_q);

  always_comb begin
    cmp_res = RES_DRAW;
    if (score1_d > score2_d) begin
      cmp_res = RES_P1;
    end else if (score2_d > score1_d) begin
      cmp_res = RES_P2;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      max_q        <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      cnt_q        <= '0;
      last_win_q   <= RES_NONE;
      last_mossa_q <= MOSSA_NONE;
      manche_q     <= RES_NONE;
      partita_q    <= RES_NONE;
    end else if (INIZIO) begin
      // A start cycle is never a round; its moves only configure the length.
      state_q      <= PLAY;
      max_q        <= max_d;
      score1_q     <= '0;
      score2_q     <= '0;
      cnt_q        <= '0;
      last_win_q   <= RES_NONE;
      last_mossa_q <= MOSSA_NONE;
      manche_q     <= RES_NONE;
      partita_q    <= RES_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          manche_q <= RES_NONE;
        end
        PLAY: begin
          manche_q <= round_res;
          if (round_valid) begin
            score1_q <= score1_d;
            score2_q <= score2_d;
            cnt_q    <= cnt_d;
            if (round_res == RES_DRAW) begin
              last_win_q   <= RES_NONE;
              last_mossa_q <= MOSSA_NONE;
            end else begin
              last_win_q   <= round_res;
              last_mossa_q <= (round_res == RES_P1) ? PRIMO : SECONDO;
            end
            // Early lead takes precedence over reaching the round limit.
            if (early_end) begin
              partita_q <= leader_res;
              state_q   <= END;
            end else if (max_end) begin
              partita_q <= cmp_res;
              state_q   <= END;
            end
          end
        end
        END: begin
          manche_q <= RES_NONE;
        end
        default: begin
          state_q  <= IDLE;
          manche_q <= RES_NONE;
        end
      endcase
    end
  end

  assign MANCHE    = manche_q;
  assign PARTITA   = partita_q;
  assign CONTEGGIO = cnt_q;

endmodule

// File: doc/morra_cinese_param.md
# morra_cinese_param

Parametrised rock-paper-scissors (morra cinese) game controller for two players. It is the next generation of the fixed-rule game FSMD and adds configurable minimum round count, winning lead, an optional no-repeat rule and a visible round counter. Each cycle it accepts one move pair and reports the round result. It also tracks the match to completion and holds the match result until a new game is started.

## Interface

Parameters:
- MIN_MANCHE, default 4. Minimum number of valid rounds before an early win is possible.
- LEAD, default 2. Score lead that ends the match early.
- NO_REPEAT, default 1. When 1, the winner of the previous round may not replay their winning move.
- CNT_W, default $clog2(MIN_MANCHE+16). Width of the round counter and score registers (localparam).

Ports:
- clk  in  1  Rising-edge clock.
- RST_N  in  1  Reset. Synchronous and active-low.
- INIZIO  in  1  Start or restart the game. Sampled at clk.
- PRIMO  in  2  Player 1 move: 00 invalid, 01 sasso, 10 carta, 11 forbice.
- SECONDO  in  2  Player 2 move, same encoding as PRIMO.
- MANCHE  out  2  Round result: 00 invalid or none, 01 P1 wins, 10 P2 wins, 11 draw.
- PARTITA  out  2  Match result: 00 ongoing or idle, 01 P1, 10 P2, 11 draw.
- CONTEGGIO  out  CNT_W  Number of valid rounds played in the current game.

## Operation

- Move precedence: sasso beats forbice, forbice beats carta, carta beats sasso. Equal moves are a draw.
- States:
  - IDLE: after reset, waiting for INIZIO.
  - PLAY
  - END: match decided.
- Priority at each edge:
  1. RST_N=0 forces IDLE and clears all registers, overriding INIZIO.
  2. INIZIO=1, from any state:
     - max = MIN_MANCHE + {PRIMO,SECONDO}, as a 4-bit unsigned value.
     - Clear scores, CONTEGGIO and the last-winner record.
     - MANCHE=00, PARTITA=00, go to PLAY.
  3. Otherwise the current state acts as described below.
- IDLE: moves are ignored. MANCHE=00.
- PLAY:
  - The round is invalid if either move is 00, or if NO_REPEAT=1 and the last winner repeats the move they won with.
  - Invalid round: MANCHE=00. Counters and the record are unchanged.
  - Draw: MANCHE=11, CONTEGGIO+1, the last-winner record is cleared.
  - Win: MANCHE=01 or 10, winner score+1, CONTEGGIO+1, the winner and their move are recorded.
- End check, using the post-update values on the same edge:
  - If CONTEGGIO ≥ MIN_MANCHE and |score1−score2| ≥ LEAD: PARTITA = leader, go to END.
  - Else if CONTEGGIO == max: PARTITA = 01, 10 or 11 by score comparison, go to END.
- END: PARTITA is held. MANCHE=00 for every move. CONTEGGIO is frozen. Only INIZIO or RST_N leaves END.
- Arithmetic: unsigned. Counters cannot overflow, because max ≤ MIN_MANCHE+15 < 2^CNT_W.

## Timing

- All outputs are registered. Inputs sampled at edge n appear on the outputs after edge n, for one cycle of latency.
- Reset value of every output is 0: MANCHE=00, PARTITA=00, CONTEGGIO=0.
- The deciding round's MANCHE and the new PARTITA update on the same edge.
- A cycle with INIZIO=1 is never a round. Its moves only configure max.
- Reset or INIZIO in mid-game aborts the match immediately, with no partial result.

## Structure

- Package morra_pkg holds:
  - move encodings (MOSSA_NONE, SASSO, CARTA, FORBICE);
  - result encodings (RES_NONE, RES_P1, RES_P2, RES_DRAW);
  - the state enum (IDLE, PLAY, END).
- Sub-module morra_judge is a combinational round evaluator:
  - Inputs: moves, last winner, last move, NO_REPEAT.
  - Output: the round result.
- The top module holds the FSM, the scores, the counter and the output registers.

## Test plan

All scenarios use the defaults (MIN_MANCHE=4, LEAD=2, NO_REPEAT=1).

- Reset: RST_N=0 for 2 cycles, with INIZIO=1 also asserted → MANCHE=00, PARTITA=00, CONTEGGIO=0, state IDLE.
- No-repeat: INIZIO with moves 00/00 (max=4), then 01/11 → MANCHE=01; then 01/10 → MANCHE=00 and CONTEGGIO stays 1; then 10/01 → MANCHE=01.
- Early win: P1 wins 10/01, 11/10, 01/11, 10/01 → PARTITA=01 at the 4th result. A following 01/10 → MANCHE=00 and PARTITA stays 01.
- Max draws: INIZIO with 10/10 (max=14), then 14 draws of 01/01 → PARTITA=11 after the 14th and CONTEGGIO=14.
- Lead check timing: P1, P2 alternating wins with max=5 → PARTITA=00 through round 4; a P1 win in round 5 → PARTITA=01 by comparison.
- Restart: INIZIO=1 mid-game after 2 rounds → CONTEGGIO=0, PARTITA=00 and a fresh max is loaded. Invalid moves 00/10 → MANCHE=00.
